data_mem_arbiter: RTL

//   Shares the single-port data memory between two requesters: port 0 (CPU load/store) and port 1 (DMA/loader).

---
 rtl/data_mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin on contention,
// bounded ownership lock for atomic read-modify-write, registered read return.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_wen,
  input  logic                  p0_lock,
  input  logic [DATA_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_wen,
  input  logic                  p1_lock,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  state_t          state, state_nxt;
  logic            last;
  logic [CW-1:0]   lock_cnt, lock_cnt_nxt;
  logic            gnt0, gnt1;
  logic            any_gnt, win_lock;

  // last holds the previous winner, so a tie goes to the other port; reset forces grants off
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (p0_req && p1_req) begin
            gnt0 = last;
            gnt1 = !last;
          end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
          end
        end
        LOCK0:   gnt0 = p0_req;
        LOCK1:   gnt1 = p1_req;
        default: ;
      endcase
    end
  end

  assign p0_gnt   = gnt0;
  assign p1_gnt   = gnt1;
  assign any_gnt  = gnt0 | gnt1;
  assign win_lock = gnt0 ? p0_lock : p1_lock;

  assign mem_addr  = gnt0 ? p0_addr  : (gnt1 ? p1_addr  : '0);
  assign mem_wdata = gnt0 ? p0_wdata : (gnt1 ? p1_wdata : '0);
  assign mem_wen   = (gnt0 & p0_wen) | (gnt1 & p1_wen);

  // In a lock state the only grant possible is to the owner, so no grant means it dropped req
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      IDLE: begin
        if (any_gnt && win_lock && (MAX_LOCK > 1)) begin
          state_nxt    = gnt0 ? LOCK0 : LOCK1;
          lock_cnt_nxt = CW'(1);
        end
      end
      LOCK0, LOCK1: begin
        if (!any_gnt || !win_lock || (lock_cnt == LOCK_LAST)) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      if (gnt0)      last <= 1'b0;
      else if (gnt1) last <= 1'b1;
    end
  end

  // rdata is held between reads; rvalid pulses only in the cycle after a granted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= gnt0 & !p0_wen;
      p1_rvalid <= gnt1 & !p1_wen;
      if (gnt0 && !p0_wen) p0_rdata <= mem_rdata;
      if (gnt1 && !p1_wen) p1_rdata <= mem_rdata;
    end
  end

endmodule
